bldc_motor_scheduler: RTL and testbench

- Sequences a bank of BLDC motor channels from a single command port.
- Accepts signed duty-cycle targets and slew-limits the applied duty once per sample tick, never reversing direction at non-zero magnitude.
- Periodically snapshots each channel's filtered encoder and hall counts, then pulses that channel's count resets.
- Latches per-channel faults, forces the faulted channel off, and holds it off until software clears the fault.

---
 rtl/bldc_motor_scheduler_if.sv | 14 +
 rtl/bldc_motor_scheduler.sv | 182 ++++++++++++++++++
 tb/tb_bldc_motor_scheduler.sv | 415 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bldc_motor_scheduler_if.sv
// Command port of the BLDC scheduler: one signed duty target per transfer,
// addressed to a single motor channel.
interface bldc_motor_scheduler_if #(
    parameter int MOTOR_W    = 3,
    parameter int DUTY_WIDTH = 10
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [MOTOR_W-1:0]    cmd_motor;
    logic [DUTY_WIDTH-1:0] cmd_duty;

    modport master (output cmd_valid, output cmd_motor, output cmd_duty, input cmd_ready);
    modport slave  (input cmd_valid, input cmd_motor, input cmd_duty, output cmd_ready);
endinterface

// File: rtl/bldc_motor_scheduler.sv
// Multi-channel BLDC sequencer: per-tick encoder/hall snapshot, slew-limited
// sign-magnitude duty ramping, and debounced per-channel fault latching.
module bldc_motor_scheduler #(
    parameter int NUM_MOTORS     = 5,
    parameter int DUTY_WIDTH     = 10,
    parameter int ENC_WIDTH      = 15,
    parameter int HALL_WIDTH     = 7,
    parameter int SAMPLE_PERIOD  = 18432,
    parameter int RAMP_STEP      = 16,
    parameter int FAULT_DEBOUNCE = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             en_all,
    bldc_motor_scheduler_if.slave            cmd,
    input  logic [NUM_MOTORS-1:0]            fault_clear,
    input  logic [NUM_MOTORS-1:0]            has_error_in,
    input  logic [NUM_MOTORS*ENC_WIDTH-1:0]  enc_count_in,
    input  logic [NUM_MOTORS*HALL_WIDTH-1:0] hall_count_in,
    output logic [NUM_MOTORS-1:0]            motor_en,
    output logic [NUM_MOTORS*DUTY_WIDTH-1:0] duty_cycle,
    output logic [NUM_MOTORS-1:0]            reset_enc_count,
    output logic [NUM_MOTORS-1:0]            reset_hall_count,
    output logic                             snap_valid,
    output logic [NUM_MOTORS*ENC_WIDTH-1:0]  snap_enc,
    output logic [NUM_MOTORS*HALL_WIDTH-1:0] snap_hall,
    output logic [NUM_MOTORS-1:0]            fault_latched
);
    localparam int IDX_W   = (NUM_MOTORS > 1) ? $clog2(NUM_MOTORS) : 1;
    localparam int MAG_W   = DUTY_WIDTH - 1;
    localparam int TIMER_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int CNT_W   = $clog2(FAULT_DEBOUNCE + 1);

    localparam logic [MAG_W-1:0]   STEP     = MAG_W'(RAMP_STEP);
    localparam logic [TIMER_W-1:0] TICK_AT  = TIMER_W'(SAMPLE_PERIOD - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(NUM_MOTORS - 1);
    localparam logic [CNT_W-1:0]   DEB_MAX  = CNT_W'(FAULT_DEBOUNCE);

    typedef enum logic [1:0] {IDLE, SNAP, RAMP} state_t;

    state_t                          state_reg;
    logic [IDX_W-1:0]                idx_reg;
    logic [TIMER_W-1:0]              timer_reg;
    logic                            cmd_ready_reg;
    logic                            snap_valid_reg;
    logic [NUM_MOTORS-1:0]           reset_cnt_reg;
    logic [NUM_MOTORS*ENC_WIDTH-1:0] snap_enc_reg;
    logic [NUM_MOTORS*HALL_WIDTH-1:0] snap_hall_reg;
    logic                            tick;
    logic                            cmd_accept;

    // A direction change always passes through zero magnitude before the sign flips.
    function automatic logic [DUTY_WIDTH-1:0] ramp_next(input logic [DUTY_WIDTH-1:0] applied,
                                                        input logic [DUTY_WIDTH-1:0] target);
        logic             a_sign;
        logic             t_sign;
        logic             n_sign;
        logic [MAG_W-1:0] m;
        logic [MAG_W-1:0] tm;
        logic [MAG_W-1:0] nm;
        a_sign = applied[DUTY_WIDTH-1];
        t_sign = target[DUTY_WIDTH-1];
        m      = applied[MAG_W-1:0];
        tm     = target[MAG_W-1:0];
        n_sign = a_sign;
        if (m == '0) begin
            n_sign = t_sign;
            nm     = (tm < STEP) ? tm : STEP;
        end else if (a_sign != t_sign) begin
            nm = (m > STEP) ? m - STEP : '0;
        end else if (tm > m) begin
            nm = ((tm - m) > STEP) ? m + STEP : tm;
        end else begin
            nm = ((m - tm) > STEP) ? m - STEP : tm;
        end
        return {n_sign & (nm != '0), nm};
    endfunction

    assign tick       = (timer_reg == TICK_AT);
    assign cmd_accept = (state_reg == IDLE) & cmd_ready_reg & cmd.cmd_valid;

    assign cmd.cmd_ready      = cmd_ready_reg;
    assign snap_valid         = snap_valid_reg;
    assign reset_enc_count    = reset_cnt_reg;
    assign reset_hall_count   = reset_cnt_reg;
    assign snap_enc           = snap_enc_reg;
    assign snap_hall          = snap_hall_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg      <= IDLE;
            idx_reg        <= '0;
            timer_reg      <= '0;
            cmd_ready_reg  <= 1'b0;
            snap_valid_reg <= 1'b0;
            reset_cnt_reg  <= '0;
            snap_enc_reg   <= '0;
            snap_hall_reg  <= '0;
        end else begin
            timer_reg      <= tick ? '0 : timer_reg + 1'b1;
            snap_valid_reg <= 1'b0;
            reset_cnt_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (tick) begin
                        state_reg      <= SNAP;
                        cmd_ready_reg  <= 1'b0;
                        snap_valid_reg <= 1'b1;
                        reset_cnt_reg  <= '1;
                        snap_enc_reg   <= enc_count_in;
                        snap_hall_reg  <= hall_count_in;
                    end else begin
                        cmd_ready_reg <= 1'b1;
                    end
                end
                SNAP: begin
                    state_reg <= RAMP;
                    idx_reg   <= '0;
                end
                RAMP: begin
                    if (idx_reg == LAST_IDX) begin
                        state_reg     <= IDLE;
                        cmd_ready_reg <= 1'b1;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_MOTORS; gi++) begin : g_ch
        logic [DUTY_WIDTH-1:0] target_reg;
        logic [DUTY_WIDTH-1:0] applied_reg;
        logic [CNT_W-1:0]      err_cnt_reg;
        logic                  latched_reg;
        logic                  motor_en_reg;
        logic                  fault_set;
        logic                  clear_ok;
        logic                  cmd_hit;
        logic                  ramp_hit;

        // Out-of-range channel indices never match, so such commands vanish.
        assign fault_set = (err_cnt_reg == DEB_MAX);
        assign clear_ok  = fault_clear[gi] & ~has_error_in[gi];
        assign cmd_hit   = cmd_accept & (cmd.cmd_motor == IDX_W'(gi));
        assign ramp_hit  = (state_reg == RAMP) & (idx_reg == IDX_W'(gi));

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                target_reg   <= '0;
                applied_reg  <= '0;
                err_cnt_reg  <= '0;
                latched_reg  <= 1'b0;
                motor_en_reg <= 1'b0;
            end else begin
                if (!has_error_in[gi])
                    err_cnt_reg <= '0;
                else if (!fault_set)
                    err_cnt_reg <= err_cnt_reg + 1'b1;
                latched_reg  <= fault_set | (latched_reg & ~clear_ok);
                motor_en_reg <= en_all & ~latched_reg;
                if (latched_reg) begin
                    target_reg  <= '0;
                    applied_reg <= '0;
                end else begin
                    if (cmd_hit)
                        target_reg <= cmd.cmd_duty;
                    if (!en_all)
                        applied_reg <= '0;
                    else if (ramp_hit)
                        applied_reg <= ramp_next(applied_reg, target_reg);
                end
            end
        end

        assign duty_cycle[gi*DUTY_WIDTH +: DUTY_WIDTH] = applied_reg;
        assign fault_latched[gi]                       = latched_reg;
        assign motor_en[gi]                            = motor_en_reg;
    end
endmodule

// File: tb/tb_bldc_motor_scheduler.sv
// Self-checking bench for bldc_motor_scheduler against a per-tick ramp model.
module tb_bldc_motor_scheduler;
    localparam int N = 5, DW = 10, EW = 15, HW = 7, P = 100, STEP = 64, FD = 4, MW = 3;

    logic              clk = 1'b0;
    logic              reset;
    logic              en_all;
    logic [N-1:0]      fault_clear;
    logic [N-1:0]      has_error_in;
    logic [N*EW-1:0]   enc_count_in;
    logic [N*HW-1:0]   hall_count_in;
    logic [N-1:0]      motor_en;
    logic [N*DW-1:0]   duty_cycle;
    logic [N-1:0]      reset_enc_count;
    logic [N-1:0]      reset_hall_count;
    logic              snap_valid;
    logic [N*EW-1:0]   snap_enc;
    logic [N*HW-1:0]   snap_hall;
    logic [N-1:0]      fault_latched;

    bldc_motor_scheduler_if #(.MOTOR_W(MW), .DUTY_WIDTH(DW)) cmd_if ();

    bldc_motor_scheduler #(
        .NUM_MOTORS(N), .DUTY_WIDTH(DW), .ENC_WIDTH(EW), .HALL_WIDTH(HW),
        .SAMPLE_PERIOD(P), .RAMP_STEP(STEP), .FAULT_DEBOUNCE(FD)
    ) dut (
        .clk(clk), .reset(reset), .en_all(en_all), .cmd(cmd_if),
        .fault_clear(fault_clear), .has_error_in(has_error_in),
        .enc_count_in(enc_count_in), .hall_count_in(hall_count_in),
        .motor_en(motor_en), .duty_cycle(duty_cycle),
        .reset_enc_count(reset_enc_count), .reset_hall_count(reset_hall_count),
        .snap_valid(snap_valid), .snap_enc(snap_enc), .snap_hall(snap_hall),
        .fault_latched(fault_latched)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: sign and magnitude per channel as plain integers.
    int tgt_s[N], tgt_m[N], app_s[N], app_m[N];
    bit lat[N];

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            tgt_s[i] = 0; tgt_m[i] = 0; app_s[i] = 0; app_m[i] = 0; lat[i] = 0;
        end
    endtask

    task automatic model_cmd(input int motor, input int duty);
        if (motor < N && !lat[motor]) begin
            tgt_s[motor] = (duty >> 9) & 1;
            tgt_m[motor] = duty & 511;
        end
    endtask

    task automatic model_tick();
        for (int i = 0; i < N; i++) begin
            if (!lat[i]) begin
                int m;
                m = app_m[i];
                if (m == 0) begin
                    app_s[i] = tgt_s[i];
                    m = (tgt_m[i] < STEP) ? tgt_m[i] : STEP;
                end else if (app_s[i] != tgt_s[i]) begin
                    m = (m > STEP) ? m - STEP : 0;
                end else if (tgt_m[i] > m) begin
                    m = (tgt_m[i] - m < STEP) ? tgt_m[i] : m + STEP;
                end else begin
                    m = (m - tgt_m[i] < STEP) ? tgt_m[i] : m - STEP;
                end
                app_m[i] = m;
                if (m == 0) app_s[i] = 0;
            end
        end
    endtask

    function automatic logic [DW-1:0] model_duty(input int i);
        return DW'(app_s[i] * 512 + app_m[i]);
    endfunction

    task automatic send_cmd(input int motor, input int duty);
        int n;
        n = 0;
        @(negedge clk);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_motor = MW'(motor);
        cmd_if.cmd_duty  = DW'(duty);
        while (!cmd_if.cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL cmd_handshake: cmd_ready=%b after %0d cycles, want 1", cmd_if.cmd_ready, n);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        model_cmd(motor, duty);
    endtask

    task automatic wait_snap(output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (!snap_valid && n < 250) begin
            @(negedge clk);
            n++;
        end
        ok = snap_valid;
    endtask

    task automatic test_reset();
        reset = 1'b1; en_all = 1'b1; fault_clear = '0; has_error_in = '0;
        enc_count_in = '0; hall_count_in = '0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_motor = '0; cmd_if.cmd_duty = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cmd_if.cmd_ready, motor_en, duty_cycle, snap_valid, reset_enc_count,
             reset_hall_count, snap_enc, snap_hall, fault_latched} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b en=%h duty=%h snap_v=%b, want all 0",
                     cmd_if.cmd_ready, motor_en, duty_cycle, snap_valid);
        end
        reset = 1'b0;
        model_reset();
        #1;
        checks++;
        if (cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL ready_at_release: got %b want 0", cmd_if.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (cmd_if.cmd_ready !== 1'b1 || motor_en !== 5'h1F || duty_cycle !== '0) begin
            errors++;
            $display("FAIL ready_after_release: ready=%b en=%h duty=%h, want 1/1f/0",
                     cmd_if.cmd_ready, motor_en, duty_cycle);
        end
    endtask

    task automatic test_snapshot();
        logic [N*EW-1:0] enc_exp;
        logic [N*HW-1:0] hall_exp;
        int k;
        enc_exp       = {N{15'h0123}};
        hall_exp      = (N*HW)'({$urandom(), $urandom()});
        enc_count_in  = enc_exp;
        hall_count_in = hall_exp;
        k = 1;
        while (!snap_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != P) begin
            errors++;
            $display("FAIL first_tick: snap_valid after %0d clocks, want %0d", k, P);
        end
        checks++;
        if (snap_enc !== enc_exp || snap_hall !== hall_exp) begin
            errors++;
            $display("FAIL snap_capture: enc=%h hall=%h want enc=%h hall=%h", snap_enc, snap_hall, enc_exp, hall_exp);
        end
        checks++;
        if (reset_enc_count !== 5'h1F || reset_hall_count !== 5'h1F || cmd_if.cmd_ready !== 1'b0) begin
            errors++;
            $display("FAIL snap_pulses: renc=%h rhall=%h ready=%b want 1f/1f/0",
                     reset_enc_count, reset_hall_count, cmd_if.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (snap_valid !== 1'b0 || reset_enc_count !== '0 || reset_hall_count !== '0) begin
            errors++;
            $display("FAIL snap_one_cycle: snap_v=%b renc=%h rhall=%h want 0", snap_valid, reset_enc_count, reset_hall_count);
        end
        repeat (5) @(negedge clk);
        model_tick();
        checks++;
        if (duty_cycle !== '0 || cmd_if.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_pass: duty=%h ready=%b want 0/1", duty_cycle, cmd_if.cmd_ready);
        end
    endtask

    task automatic test_ramp_directed();
        int exp_up[4]   = '{64, 128, 192, 200};
        int exp_down[6] = '{136, 72, 8, 0, 'h240, 'h264};
        bit ok;
        send_cmd(2, 'h0C8);
        for (int p = 0; p < 10; p++) begin
            int want;
            if (p == 4) send_cmd(2, 'h264);
            want = (p < 4) ? exp_up[p] : exp_down[p-4];
            wait_snap(ok);
            repeat (6) @(negedge clk);
            model_tick();
            checks++;
            if (!ok || duty_cycle[2*DW +: DW] !== DW'(want)) begin
                errors++;
                $display("FAIL ramp_ch2 pass %0d: got 0x%03h want 0x%03h (tick_seen=%b)", p, duty_cycle[2*DW +: DW], want, ok);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (duty_cycle[i*DW +: DW] !== model_duty(i)) begin
                    errors++;
                    $display("FAIL ramp_model ch%0d pass %0d: got 0x%03h want 0x%03h", i, p, duty_cycle[i*DW +: DW], model_duty(i));
                end
            end
        end
    endtask

    task automatic test_fault();
        bit ok;
        send_cmd(1, 100);
        wait_snap(ok);
        repeat (6) @(negedge clk);
        model_tick();
        checks++;
        if (!ok || duty_cycle[1*DW +: DW] !== 10'd64) begin
            errors++;
            $display("FAIL fault_pre ch1: got 0x%03h want 0x040", duty_cycle[1*DW +: DW]);
        end
        has_error_in[1] = 1'b1;
        repeat (3) @(negedge clk);
        has_error_in[1] = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (fault_latched !== '0 || motor_en !== 5'h1F) begin
            errors++;
            $display("FAIL fault_3clk: latched=%h en=%h want 00/1f", fault_latched, motor_en);
        end
        has_error_in[1] = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (fault_latched[1] !== 1'b0) begin
            errors++;
            $display("FAIL fault_not_yet: latched=%b want 0", fault_latched[1]);
        end
        @(negedge clk);
        checks++;
        if (fault_latched !== 5'h02) begin
            errors++;
            $display("FAIL fault_latch: latched=%h want 02", fault_latched);
        end
        lat[1] = 1; tgt_s[1] = 0; tgt_m[1] = 0; app_s[1] = 0; app_m[1] = 0;
        repeat (2) @(negedge clk);
        checks++;
        if (motor_en !== 5'h1D || duty_cycle[1*DW +: DW] !== '0) begin
            errors++;
            $display("FAIL fault_force_off: en=%h duty1=0x%03h want 1d/000", motor_en, duty_cycle[1*DW +: DW]);
        end
        fault_clear[1] = 1'b1;
        @(negedge clk);
        fault_clear[1] = 1'b0;
        @(negedge clk);
        checks++;
        if (fault_latched[1] !== 1'b1) begin
            errors++;
            $display("FAIL clear_ignored: latched=%b want 1", fault_latched[1]);
        end
        send_cmd(1, 300);
        has_error_in[1] = 1'b0;
        repeat (3) @(negedge clk);
        fault_clear[1] = 1'b1;
        @(negedge clk);
        fault_clear[1] = 1'b0;
        checks++;
        if (fault_latched !== '0) begin
            errors++;
            $display("FAIL clear_taken: latched=%h want 00", fault_latched);
        end
        lat[1] = 0;
        @(negedge clk);
        checks++;
        if (motor_en !== 5'h1F) begin
            errors++;
            $display("FAIL motor_en_restore: en=%h want 1f", motor_en);
        end
        for (int p = 0; p < 2; p++) begin
            if (p == 1) send_cmd(1, 'h232);
            wait_snap(ok);
            repeat (6) @(negedge clk);
            model_tick();
            checks++;
            if (!ok || duty_cycle[1*DW +: DW] !== ((p == 0) ? 10'h000 : 10'h232)) begin
                errors++;
                $display("FAIL post_clear ch1 pass %0d: got 0x%03h want 0x%03h", p, duty_cycle[1*DW +: DW], (p == 0) ? 0 : 'h232);
            end
            for (int i = 0; i < N; i++) begin
                checks++;
                if (duty_cycle[i*DW +: DW] !== model_duty(i)) begin
                    errors++;
                    $display("FAIL post_clear_model ch%0d: got 0x%03h want 0x%03h", i, duty_cycle[i*DW +: DW], model_duty(i));
                end
            end
        end
    endtask

    task automatic test_held_cmd();
        bit ok;
        int low;
        wait_snap(ok);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_motor = 3'd7;
        cmd_if.cmd_duty  = 10'h3FF;
        low = 0;
        while (!cmd_if.cmd_ready && low < 20) begin
            low++;
            @(negedge clk);
        end
        checks++;
        if (!ok || low != 6) begin
            errors++;
            $display("FAIL held_cmd_ready_low: low for %0d cycles, want 6 (tick_seen=%b)", low, ok);
        end
        @(negedge clk);
        cmd_if.cmd_valid = 1'b0;
        model_tick();
        model_cmd(7, 'h3FF);
        for (int i = 0; i < N; i++) begin
            checks++;
            if (duty_cycle[i*DW +: DW] !== model_duty(i)) begin
                errors++;
                $display("FAIL held_model ch%0d: got 0x%03h want 0x%03h", i, duty_cycle[i*DW +: DW], model_duty(i));
            end
        end
    endtask

    task automatic test_random();
        bit ok;
        for (int t = 0; t < 8; t++) begin
            logic [N*EW-1:0] enc_exp;
            logic [N*HW-1:0] hall_exp;
            int ncmd;
            enc_exp       = (N*EW)'({$urandom(), $urandom(), $urandom()});
            hall_exp      = (N*HW)'({$urandom(), $urandom()});
            enc_count_in  = enc_exp;
            hall_count_in = hall_exp;
            ncmd = $urandom_range(0, 3);
            for (int c = 0; c < ncmd; c++)
                send_cmd($urandom_range(0, 7), $urandom_range(0, 1023));
            wait_snap(ok);
            checks++;
            if (!ok || snap_enc !== enc_exp || snap_hall !== hall_exp || reset_enc_count !== 5'h1F) begin
                errors++;
                $display("FAIL rand_snap %0d: enc=%h hall=%h renc=%h want enc=%h hall=%h renc=1f",
                         t, snap_enc, snap_hall, reset_enc_count, enc_exp, hall_exp);
            end
            repeat (6) @(negedge clk);
            model_tick();
            for (int i = 0; i < N; i++) begin
                checks++;
                if (duty_cycle[i*DW +: DW] !== model_duty(i)) begin
                    errors++;
                    $display("FAIL rand_model tick %0d ch%0d: got 0x%03h want 0x%03h", t, i, duty_cycle[i*DW +: DW], model_duty(i));
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        bit ok;
        int k;
        send_cmd(0, 'h1FF);
        wait_snap(ok);
        repeat (6) @(negedge clk);
        model_tick();
        wait_snap(ok);
        repeat (4) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (!ok || {cmd_if.cmd_ready, motor_en, duty_cycle, snap_valid, reset_enc_count,
                    reset_hall_count, snap_enc, snap_hall, fault_latched} !== '0) begin
            errors++;
            $display("FAIL async_reset: ready=%b en=%h duty=%h snap_enc=%h, want all 0",
                     cmd_if.cmd_ready, motor_en, duty_cycle, snap_enc);
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        model_reset();
        k = 0;
        while (!snap_valid && k < 300) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != P) begin
            errors++;
            $display("FAIL tick_after_reset: snap_valid after %0d clocks, want %0d", k, P);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (duty_cycle !== '0) begin
            errors++;
            $display("FAIL duty_after_reset: got %h want 0", duty_cycle);
        end
    endtask

    initial begin
        test_reset();
        test_snapshot();
        test_ramp_directed();
        test_fault();
        test_held_cmd();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
